// File: rtl/cpu_trace_pkg.sv
// ---------------------------------------------------------------------------
// cpu_trace_pkg
// Shared types and constants for the CPU execution trace monitor.
//   trace_kind_e   : kind field of a trace entry (FETCH / STORE)
//   halt_reason_e  : encoding reported on halt_reason
//   mon_state_e    : monitor FSM states
//   trace_entry_t  : one 66-bit trace record {kind, pc, payload}
// ---------------------------------------------------------------------------
package cpu_trace_pkg;

    localparam int TRACE_W    = 66;
    localparam int PC_TRACE_W = 32;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        STORE = 2'b01
    } trace_kind_e;

    typedef enum logic [1:0] {
        HALT_NONE   = 2'b00,
        HALT_BUDGET = 2'b01,
        HALT_STALL  = 2'b10,
        HALT_EXC    = 2'b11
    } halt_reason_e;

    typedef enum logic [1:0] {
        WAIT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } mon_state_e;

    typedef struct packed {
        trace_kind_e             kind;
        logic [PC_TRACE_W-1:0]   pc;
        logic [31:0]             payload;
    } trace_entry_t;

endpackage

// File: rtl/cpu_trace_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_trace_monitor_if
// Valid/ready trace stream leaving the monitor.
//   trace_data  : {kind[1:0], pc[31:0], payload[31:0]}
//   trace_valid : an entry is presented
//   trace_ready : consumer accepts the entry (pop when valid & ready)
// Modports: master = monitor side, slave = consumer side.
// ---------------------------------------------------------------------------
interface cpu_trace_monitor_if;
    import cpu_trace_pkg::*;

    logic [TRACE_W-1:0] trace_data;
    logic               trace_valid;
    logic               trace_ready;

    modport master (output trace_data, output trace_valid, input trace_ready);
    modport slave  (input trace_data, input trace_valid, output trace_ready);

endinterface

// File: rtl/cpu_trace_monitor_trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO whose head entry is held in an output register, so a push
// into an empty FIFO is visible on o_data right after the pushing edge.
//   clock, reset : clock, asynchronous active-low reset
//   i_push, i_pushData, o_full : write side (push ignored when full unless
//                                a pop happens in the same cycle)
//   i_pop, o_valid, o_data     : read side (pop when o_valid & i_pop)
// ---------------------------------------------------------------------------
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int WIDTH = TRACE_W,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    r_wrPtr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_popEff;
    logic             w_pushEff;
    logic [AW-1:0]    w_rdPtrNext;
    logic [AW:0]      w_countNext;
    logic [WIDTH-1:0] w_headNext;

    assign o_valid     = (r_count != '0);
    assign o_full      = (r_count == (AW+1)'(DEPTH));
    assign o_data      = r_head;
    assign w_popEff    = i_pop && o_valid;
    assign w_pushEff   = i_push && (!o_full || w_popEff);
    assign w_rdPtrNext = w_popEff ? r_rdPtr + 1'b1 : r_rdPtr;
    assign w_countNext = r_count + {{AW{1'b0}}, w_pushEff} - {{AW{1'b0}}, w_popEff};

    // The next head bypasses the array when the slot it lives in is the one
    // being written this cycle (FIFO empty after any pop).
    always_comb begin
        w_headNext = '0;
        if (w_countNext != '0) begin
            if (w_pushEff && (r_wrPtr == w_rdPtrNext)) begin
                w_headNext = i_pushData;
            end else begin
                w_headNext = r_mem[w_rdPtrNext];
            end
        end
    end

    // Storage array; contents are meaningless after reset since pointers clear.
    always_ff @(posedge clock) begin
        if (w_pushEff) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            r_rdPtr <= w_rdPtrNext;
            if (w_pushEff) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            r_count <= w_countNext;
            r_head  <= w_headNext;
        end
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// ---------------------------------------------------------------------------
// cpu_trace_monitor
// Watches the multicycle CPU debug outputs, logs fetch (and optionally store)
// events into a drainable trace FIFO, counts cycles/fetches/drops and raises
// a sticky halt on budget exhaustion, PC stall or a nonzero cause register.
// Optional feature macro: TRACE_MEM_EN (capture memoria_wr stores as kind=01).
//   clock, reset         : clock, asynchronous active-low reset
//   Pc_Out, Instruction  : CPU PC and IR contents
//   ULA_Out, memoria_wr  : ALU result (store address) and data write strobe
//   Ld_ir                : IR load strobe, one pulse per fetch
//   Reg_Caua             : exception cause register
//   trace                : trace stream (data/valid out, ready in)
//   cycle_count, instr_count, drop_count : saturating statistics
//   halted, halt_reason  : sticky halt flag and its cause
// ---------------------------------------------------------------------------
module cpu_trace_monitor
    import cpu_trace_pkg::*;
#(
    parameter int MAX_CYCLES  = 300,
    parameter int STALL_LIMIT = 64,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [63:0]          Pc_Out,
    input  logic [31:0]          Instruction,
    input  logic [63:0]          ULA_Out,
    input  logic                 Ld_ir,
    input  logic                 memoria_wr,
    input  logic [63:0]          Reg_Caua,
    cpu_trace_monitor_if.master  trace,
    output logic [31:0]          cycle_count,
    output logic [31:0]          instr_count,
    output logic [15:0]          drop_count,
    output logic                 halted,
    output logic [1:0]           halt_reason
);

    mon_state_e   r_state;
    mon_state_e   w_nextState;
    halt_reason_e r_haltReason;
    halt_reason_e w_haltReason;

    logic [63:0]  r_pcPrev;
    logic [31:0]  r_stall;
    logic [31:0]  r_cycle;
    logic [31:0]  r_instr;
    logic [15:0]  r_drop;

    logic         w_capture;
    logic         w_runCycle;
    logic [31:0]  w_cycleNext;
    logic [31:0]  w_stallNext;
    logic         w_exc;
    logic         w_stallHit;
    logic         w_budgetHit;
    logic         w_haltReq;

    logic         w_fetchEvt;
    logic         w_pushReq;
    logic         w_conflictDrop;
    logic         w_fullDrop;
    trace_entry_t w_pushEntry;
    logic         w_fifoFull;
    logic         w_fifoValid;
    logic [TRACE_W-1:0] w_fifoData;
    logic         w_popEff;
    logic [16:0]  w_dropSum;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: the first fetch starts the run, any halt cause ends it
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            WAIT:    if (Ld_ir) w_nextState = RUN;
            RUN:     if (w_haltReq) w_nextState = HALT;
            HALT:    w_nextState = HALT;
            default: w_nextState = WAIT;
        endcase
    end

    // FSM outputs: the fetch that leaves WAIT is itself captured
    always_comb begin
        w_capture  = 1'b0;
        w_runCycle = 1'b0;
        case (r_state)
            WAIT:    w_capture = Ld_ir;
            RUN: begin
                w_capture  = 1'b1;
                w_runCycle = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cycleNext = (r_cycle == '1) ? r_cycle : r_cycle + 32'd1;
    assign w_stallNext = ((Pc_Out != r_pcPrev) || Ld_ir) ? 32'd0 :
                         ((r_stall == '1) ? r_stall : r_stall + 32'd1);

    assign w_exc       = w_runCycle && (Reg_Caua != '0);
    assign w_stallHit  = w_runCycle && (w_stallNext >= 32'(STALL_LIMIT));
    assign w_budgetHit = w_runCycle && (w_cycleNext >= 32'(MAX_CYCLES));
    assign w_haltReq   = w_exc || w_stallHit || w_budgetHit;

    // Exception outranks stall, which outranks budget
    always_comb begin
        w_haltReason = HALT_NONE;
        if (w_exc) begin
            w_haltReason = HALT_EXC;
        end else if (w_stallHit) begin
            w_haltReason = HALT_STALL;
        end else if (w_budgetHit) begin
            w_haltReason = HALT_BUDGET;
        end
    end

    assign w_fetchEvt = w_capture && Ld_ir;

`ifdef TRACE_MEM_EN
    logic w_storeEvt;
    logic w_unusedBits;
    assign w_storeEvt     = w_capture && memoria_wr;
    assign w_conflictDrop = w_fetchEvt && w_storeEvt;
    assign w_pushReq      = w_fetchEvt || w_storeEvt;
    assign w_unusedBits   = ^ULA_Out[63:32];

    // A fetch wins a same-cycle conflict; the store is counted as a drop
    always_comb begin
        w_pushEntry.kind    = w_fetchEvt ? FETCH : STORE;
        w_pushEntry.pc      = Pc_Out[PC_TRACE_W-1:0];
        w_pushEntry.payload = w_fetchEvt ? Instruction : ULA_Out[31:0];
    end
`else
    logic w_unusedBits;
    assign w_conflictDrop = 1'b0;
    assign w_pushReq      = w_fetchEvt;
    assign w_unusedBits   = ^{memoria_wr, ULA_Out};

    always_comb begin
        w_pushEntry.kind    = FETCH;
        w_pushEntry.pc      = Pc_Out[PC_TRACE_W-1:0];
        w_pushEntry.payload = Instruction;
    end
`endif

    assign w_popEff   = w_fifoValid && trace.trace_ready;
    assign w_fullDrop = w_pushReq && w_fifoFull && !w_popEff;
    assign w_dropSum  = {1'b0, r_drop} + {16'd0, w_fullDrop} + {16'd0, w_conflictDrop};

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_traceFifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_pushReq),
        .i_pushData (w_pushEntry),
        .o_full     (w_fifoFull),
        .i_pop      (trace.trace_ready),
        .o_valid    (w_fifoValid),
        .o_data     (w_fifoData)
    );

    // Statistics and stall tracking; nothing moves once halted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pcPrev     <= '0;
            r_stall      <= '0;
            r_cycle      <= '0;
            r_instr      <= '0;
            r_drop       <= '0;
            r_haltReason <= HALT_NONE;
        end else begin
            r_pcPrev <= Pc_Out;
            if (w_runCycle) begin
                r_cycle <= w_cycleNext;
                r_stall <= w_stallNext;
            end
            if (w_fetchEvt && (r_instr != '1)) begin
                r_instr <= r_instr + 32'd1;
            end
            r_drop <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
            if (w_runCycle && w_haltReq) begin
                r_haltReason <= w_haltReason;
            end
        end
    end

    assign trace.trace_valid = w_fifoValid;
    assign trace.trace_data  = w_fifoData;
    assign cycle_count       = r_cycle;
    assign instr_count       = r_instr;
    assign drop_count        = r_drop;
    assign halted            = (r_state == HALT);
    assign halt_reason       = r_haltReason;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_trace_monitor
// Scoreboard bench for cpu_trace_monitor: expected trace entries are queued
// as events are driven and compared as the consumer pops them.
// Honours TRACE_MEM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cpu_trace_monitor;

    localparam int MAX_CYCLES  = 300;
    localparam int STALL_LIMIT = 64;
    localparam int FIFO_DEPTH  = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] Pc_Out = '0;
    logic [31:0] Instruction = '0;
    logic [63:0] ULA_Out = '0;
    logic        Ld_ir = 1'b0;
    logic        memoria_wr = 1'b0;
    logic [63:0] Reg_Caua = '0;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [15:0] drop_count;
    logic        halted;
    logic [1:0]  halt_reason;

    cpu_trace_monitor_if traceIf ();

    cpu_trace_monitor #(
        .MAX_CYCLES  (MAX_CYCLES),
        .STALL_LIMIT (STALL_LIMIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .Pc_Out      (Pc_Out),
        .Instruction (Instruction),
        .ULA_Out     (ULA_Out),
        .Ld_ir       (Ld_ir),
        .memoria_wr  (memoria_wr),
        .Reg_Caua    (Reg_Caua),
        .trace       (traceIf),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .drop_count  (drop_count),
        .halted      (halted),
        .halt_reason (halt_reason)
    );

    // 10 time-unit clock
    always #5 clock = ~clock;

    int nChecks = 0;
    int nPassed = 0;

    logic [65:0] sbQueue [$];
    bit          modelRunning;
    bit          modelHalted;
    int          modelCycles;
    int          modelInstr;
    int          modelDrops;
    int          modelStall;
    logic [1:0]  modelReason;
    logic [63:0] modelPrevPc;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [65:0] actual, input logic [65:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelPush(input logic [65:0] entry);
        if (sbQueue.size() < FIFO_DEPTH) sbQueue.push_back(entry);
        else modelDrops++;
    endtask

    // Drive one clock edge worth of CPU activity (called at a falling edge),
    // update the reference model and optionally pop one trace entry.
    task automatic applyStimulus(input logic [63:0] pc, input logic ld, input logic [31:0] instr,
                                 input logic wr, input logic [63:0] ula, input logic [63:0] cause,
                                 input logic pop);
        bit capture;
        Pc_Out      = pc;
        Ld_ir       = ld;
        Instruction = instr;
        memoria_wr  = wr;
        ULA_Out     = ula;
        Reg_Caua    = cause;
        traceIf.trace_ready = pop;

        if (pop && traceIf.trace_valid) begin
            if (sbQueue.size() == 0) checkOutput("popExtra", {65'd0, traceIf.trace_valid}, 66'd0);
            else checkOutput("popHead", traceIf.trace_data, sbQueue.pop_front());
        end else if (pop && sbQueue.size() != 0) begin
            checkOutput("popValid", {65'd0, traceIf.trace_valid}, 66'd1);
        end

        capture = !modelHalted && (modelRunning || ld);
        if (capture) begin
            if (ld) begin
                modelInstr++;
                modelPush({2'b00, pc[31:0], instr});
            end
`ifdef TRACE_MEM_EN
            if (wr) begin
                if (ld) modelDrops++;
                else modelPush({2'b01, pc[31:0], ula[31:0]});
            end
`endif
        end

        if (modelRunning && !modelHalted) begin
            modelCycles++;
            if ((pc != modelPrevPc) || ld) modelStall = 0;
            else modelStall++;
            if (cause != 64'd0) begin
                modelHalted = 1'b1; modelReason = 2'b11;
            end else if (modelStall >= STALL_LIMIT) begin
                modelHalted = 1'b1; modelReason = 2'b10;
            end else if (modelCycles >= MAX_CYCLES) begin
                modelHalted = 1'b1; modelReason = 2'b01;
            end
        end
        if (!modelRunning && ld) modelRunning = 1'b1;
        modelPrevPc = pc;

        @(negedge clock);
        Ld_ir      = 1'b0;
        memoria_wr = 1'b0;
        Reg_Caua   = '0;
        traceIf.trace_ready = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(Pc_Out, 1'b0, 32'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_cycles"}, {34'd0, cycle_count}, 66'(modelCycles));
        checkOutput({tag, "_instr"},  {34'd0, instr_count}, 66'(modelInstr));
        checkOutput({tag, "_drops"},  {50'd0, drop_count},  66'(modelDrops));
        checkOutput({tag, "_halted"}, {65'd0, halted},      {65'd0, modelHalted});
        checkOutput({tag, "_reason"}, {64'd0, halt_reason}, {64'd0, modelReason});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"},  {65'd0, traceIf.trace_valid}, 66'd0);
        checkOutput({tag, "_data"},   traceIf.trace_data, 66'd0);
        checkOutput({tag, "_cycles"}, {34'd0, cycle_count}, 66'd0);
        checkOutput({tag, "_instr"},  {34'd0, instr_count}, 66'd0);
        checkOutput({tag, "_drops"},  {50'd0, drop_count},  66'd0);
        checkOutput({tag, "_halted"}, {65'd0, halted},      66'd0);
        checkOutput({tag, "_reason"}, {64'd0, halt_reason}, 66'd0);
    endtask

    task automatic clearModel();
        sbQueue.delete();
        modelRunning = 1'b0;
        modelHalted  = 1'b0;
        modelCycles  = 0;
        modelInstr   = 0;
        modelDrops   = 0;
        modelStall   = 0;
        modelReason  = 2'b00;
        modelPrevPc  = '0;
    endtask

    task automatic resetDut(input string tag);
        reset = 1'b0;
        Pc_Out = '0; Instruction = '0; ULA_Out = '0; Reg_Caua = '0;
        Ld_ir = 1'b0; memoria_wr = 1'b0; traceIf.trace_ready = 1'b0;
        repeat (2) @(negedge clock);
        checkResetValues(tag);
        clearModel();
        reset = 1'b1;
    endtask

    // Pop everything the DUT holds, comparing each entry with the scoreboard
    task automatic drainFifo(input string tag);
        for (int i = 0; i < FIFO_DEPTH + 4 && traceIf.trace_valid; i++) begin
            applyStimulus(Pc_Out, 1'b0, 32'd0, 1'b0, 64'd0, 64'd0, 1'b1);
        end
        checkOutput({tag, "_sbEmpty"}, 66'(sbQueue.size()), 66'd0);
        checkOutput({tag, "_validLow"}, {65'd0, traceIf.trace_valid}, 66'd0);
    endtask

    // First fetch at PC 0 then 'lastEdge' RUN cycles with a fetch every 8
    task automatic runWithFetches(input int lastEdge);
        applyStimulus(64'd0, 1'b1, 32'hD000_0000, 1'b0, 64'd0, 64'd0, 1'b0);
        for (int e = 1; e <= lastEdge; e++) begin
            if ((e % 8) == 0)
                applyStimulus(64'(4 * e), 1'b1, 32'hD000_0000 + 32'(e), 1'b0, 64'd0, 64'd0, 1'b0);
            else
                idleCycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearModel();

        // Five fetches four cycles apart
        resetDut("rst");
        repeat (3) idleCycle();
        checkOutput("t1_waitCycles", {34'd0, cycle_count}, 66'd0);
        checkOutput("t1_waitValid", {65'd0, traceIf.trace_valid}, 66'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(64'(4 * k), 1'b1, 32'hA000_0000 + 32'(k), 1'b0, 64'd0, 64'd0, 1'b0);
            if (k == 0) checkOutput("t1_validRise", {65'd0, traceIf.trace_valid}, 66'd1);
            if (k < 4) repeat (3) idleCycle();
        end
        checkOutput("t1_instr", {34'd0, instr_count}, 66'd5);
        checkOutput("t1_drops", {50'd0, drop_count}, 66'd0);
        checkOutput("t1_cycles", {34'd0, cycle_count}, 66'd16);
        checkOutput("t1_head", traceIf.trace_data, {2'b00, 32'd0, 32'hA000_0000});
        drainFifo("t1");

        // Overflow, then push and pop together while full
        resetDut("rst2");
        for (int i = 0; i < 20; i++)
            applyStimulus(64'h100 + 64'(4 * i), 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 64'd0, 64'd0, 1'b0);
        checkOutput("t2_instr", {34'd0, instr_count}, 66'd20);
        checkOutput("t2_drops", {50'd0, drop_count}, 66'd4);
        applyStimulus(64'h200, 1'b1, 32'h0000_BEEF, 1'b0, 64'd0, 64'd0, 1'b1);
        checkOutput("t2_fullPopDrops", {50'd0, drop_count}, 66'd4);
        checkCounters("t2");
        drainFifo("t2");

        // PC stall at 0x40
        resetDut("rst3");
        applyStimulus(64'h40, 1'b1, 32'hC000_0040, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (STALL_LIMIT - 1) idleCycle();
        checkOutput("t3_notYet", {65'd0, halted}, 66'd0);
        idleCycle();
        checkOutput("t3_halted", {65'd0, halted}, 66'd1);
        checkOutput("t3_reason", {64'd0, halt_reason}, 66'd2);
        checkOutput("t3_cycles", {34'd0, cycle_count}, 66'd64);
        applyStimulus(64'h44, 1'b1, 32'h0000_DEAD, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) idleCycle();
        checkOutput("t3_frozenCycles", {34'd0, cycle_count}, 66'd64);
        checkOutput("t3_frozenInstr", {34'd0, instr_count}, 66'd1);
        checkCounters("t3");
        drainFifo("t3");

        // Cycle budget
        resetDut("rst4");
        runWithFetches(MAX_CYCLES - 1);
        checkOutput("t4_notYet", {65'd0, halted}, 66'd0);
        checkOutput("t4_cycles299", {34'd0, cycle_count}, 66'd299);
        idleCycle();
        checkOutput("t4_halted", {65'd0, halted}, 66'd1);
        checkOutput("t4_reason", {64'd0, halt_reason}, 66'd1);
        checkOutput("t4_cycles300", {34'd0, cycle_count}, 66'd300);
        applyStimulus(64'h9000, 1'b1, 32'h0000_0BAD, 1'b0, 64'd0, 64'd0, 1'b0);
        checkOutput("t4_instrFrozen", {34'd0, instr_count}, 66'd38);
        checkOutput("t4_drops", {50'd0, drop_count}, 66'd22);
        checkCounters("t4");
        drainFifo("t4");

        // Exception in the same cycle the budget expires
        resetDut("rst5");
        runWithFetches(MAX_CYCLES - 1);
        applyStimulus(Pc_Out, 1'b0, 32'd0, 1'b0, 64'd0, 64'd1, 1'b0);
        checkOutput("t5_halted", {65'd0, halted}, 66'd1);
        checkOutput("t5_reason", {64'd0, halt_reason}, 66'd3);
        checkCounters("t5");
        drainFifo("t5");

        // Store capture and fetch/store conflict
        resetDut("rst6");
        applyStimulus(64'h200, 1'b1, 32'h0000_00E1, 1'b0, 64'd0, 64'd0, 1'b0);
        applyStimulus(64'h204, 1'b0, 32'd0, 1'b1, 64'h100, 64'd0, 1'b0);
        checkOutput("t6_storeDrops", {50'd0, drop_count}, 66'd0);
        applyStimulus(64'h208, 1'b1, 32'h0000_00E2, 1'b1, 64'h300, 64'd0, 1'b0);
`ifdef TRACE_MEM_EN
        checkOutput("t6_conflictDrops", {50'd0, drop_count}, 66'd1);
        checkOutput("t6_sbStore", sbQueue[1], {2'b01, 32'h204, 32'h100});
`else
        checkOutput("t6_noMemDrops", {50'd0, drop_count}, 66'd0);
`endif
        checkOutput("t6_instr", {34'd0, instr_count}, 66'd2);
        drainFifo("t6");

        // Asynchronous reset in the middle of a run
        resetDut("rst7");
        for (int i = 0; i < 3; i++)
            applyStimulus(64'h500 + 64'(4 * i), 1'b1, 32'hF000_0000 + 32'(i), 1'b0, 64'd0, 64'd0, 1'b0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 checkResetValues("t7_async");
        @(negedge clock);
        clearModel();
        reset = 1'b1;
        applyStimulus(64'h600, 1'b1, 32'hF000_0600, 1'b0, 64'd0, 64'd0, 1'b0);
        drainFifo("t7");

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
